// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
//
// Round-robin arbiter that lets NUM_MASTERS Wishbone masters share a single
// slave. An idle arbiter registers a one-hot grant one clock after it sees a
// request. The owner keeps the bus for as long as it holds m_cyc, so bursts
// and locked sequences are never split. A stall watchdog ends any access that
// the slave leaves without ack/err for TIMEOUT_CYCLES strobe cycles. It does
// this by raising err to the owner and pulsing timeout for one cycle.
//
// Ports
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   m_cyc/m_stb/m_we      : per-master cycle, strobe, write enable
//   m_adr/m_sel/m_dat_mosi: per-master address, byte select, write data
//                           (master i occupies slice i)
//   m_ack/m_err           : per-master response, only the owner sees it
//   m_dat_miso            : read data, s_dat_miso broadcast to every slice
//   s_*                   : single slave port, driven by the owner while busy
//   grant                 : one-hot owner, all-zero when idle
//   timeout               : one-cycle pulse when a stalled access is aborted
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]   m_sel,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_mosi,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_miso,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [ADDR_WIDTH-1:0]              s_adr,
    output logic [SEL_WIDTH-1:0]               s_sel,
    output logic [DATA_WIDTH-1:0]              s_dat_mosi,
    input  logic                               s_ack,
    input  logic                               s_err,
    input  logic [DATA_WIDTH-1:0]              s_dat_miso,
    output logic [NUM_MASTERS-1:0]             grant,
    output logic                               timeout
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         last_owner_q, last_owner_d;
    logic [15:0]              cnt_q, cnt_d;

    logic                     req_found_s;
    logic [IDX_W-1:0]         req_pick_s;
    logic [IDX_W:0]           cand_s;
    logic                     owner_cyc_s;
    logic                     owner_stb_s;
    logic                     stall_s;
    logic                     timeout_s;

    // State register: every flop of the arbiter, reset synchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= {NUM_MASTERS{1'b0}};
            owner_q      <= {IDX_W{1'b0}};
            last_owner_q <= IDX_W'(NUM_MASTERS - 1);
            cnt_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    // Round-robin search: the first requester after the previous owner wins,
    // and the index wraps modulo NUM_MASTERS.
    always_comb begin
        req_found_s = 1'b0;
        req_pick_s  = {IDX_W{1'b0}};
        cand_s      = {(IDX_W+1){1'b0}};
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_s = {1'b0, last_owner_q} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            if (!req_found_s && m_cyc[cand_s[IDX_W-1:0]]) begin
                req_found_s = 1'b1;
                req_pick_s  = cand_s[IDX_W-1:0];
            end else begin
                req_found_s = req_found_s;
            end
        end
    end

    // Owner's cycle/strobe. grant_q is all-zero in IDLE, so these are 0 there.
    always_comb begin
        owner_cyc_s = |(m_cyc & grant_q);
        owner_stb_s = |(m_stb & grant_q);
    end

    // Stall watchdog. An ack or err in the expiry cycle takes priority over the abort.
    always_comb begin
        stall_s   = (state_q == BUSY) && owner_stb_s && !s_ack && !s_err;
        timeout_s = stall_s && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
        if (stall_s && !timeout_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Next-state logic. Releasing the bus always costs one IDLE cycle before
    // the next grant.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (req_found_s) begin
                    state_d = BUSY;
                    owner_d = req_pick_s;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (req_pick_s == IDX_W'(i));
                    end
                end else begin
                    grant_d = {NUM_MASTERS{1'b0}};
                end
            end
            BUSY: begin
                if (!owner_cyc_s) begin
                    state_d      = IDLE;
                    grant_d      = {NUM_MASTERS{1'b0}};
                    last_owner_d = owner_q;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {NUM_MASTERS{1'b0}};
            end
        endcase
    end

    // Output mux. The owner connects straight to the slave, and everyone else
    // sees a quiet bus.
    always_comb begin
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_adr      = {ADDR_WIDTH{1'b0}};
        s_sel      = {SEL_WIDTH{1'b0}};
        s_dat_mosi = {DATA_WIDTH{1'b0}};
        m_ack      = {NUM_MASTERS{1'b0}};
        m_err      = {NUM_MASTERS{1'b0}};
        m_dat_miso = {NUM_MASTERS{s_dat_miso}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if ((state_q == BUSY) && grant_q[i]) begin
                s_cyc      = m_cyc[i];
                s_stb      = m_stb[i];
                s_we       = m_we[i];
                s_adr      = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_sel      = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
                s_dat_mosi = m_dat_mosi[i*DATA_WIDTH +: DATA_WIDTH];
                m_ack[i]   = s_ack;
                m_err[i]   = s_err | timeout_s;
            end else begin
                m_ack[i] = 1'b0;
                m_err[i] = 1'b0;
            end
        end
    end

    assign grant   = grant_q;
    assign timeout = timeout_s;

endmodule
